// File: rtl/snake_dir_ctrl.sv
// Direction input conditioner: debounces four buttons, filters and queues turns, releases one per move tick.
// Latency: raw edge to press event 2+DEB_CYCLES cycles; the push/drop decision lands one cycle later.
// Backpressure: none upstream; a valid press into a full queue is dropped and flagged in sticky ovf.
// Optional reversal guard: define SNAKE_DIR_REVERSAL_GUARD_EN to also reject presses opposite the reference direction.
// Direction codes double as button indices: left=00, down=01, up=10, right=11.
module snake_dir_ctrl #(
  parameter int         DEB_CYCLES = 20000,
  parameter int         Q_DEPTH    = 2,
  parameter logic [1:0] INIT_DIR   = 2'b11
) (
  input  logic                       clk,
  input  logic                       clear_n,
  input  logic [3:0]                 btn,
  input  logic                       move_tick,
  input  logic                       game_clear,
  output logic [1:0]                 dir,
  output logic                       turned,
  output logic [$clog2(Q_DEPTH):0]   q_level,
  output logic                       drop,
  output logic                       ovf
);

  // Debounce counter width; DEB_CYCLES is expected to be at least 2.
  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  // FIFO pointer width; Q_DEPTH is a power of two so pointers wrap naturally.
  localparam int PW = $clog2(Q_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEB_CYCLES - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(Q_DEPTH);

  logic [3:0] sync_a;
  logic [3:0] sync_b;
  logic [3:0] press;

  // Two-flop synchroniser for the raw buttons.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
    end
  end

  // One debouncer per button; press[i] pulses for one cycle when the stable level rises.
  for (genvar i = 0; i < 4; i++) begin : g_deb
    logic [CW-1:0] cnt;
    logic          stab;
    logic          prs;

    // Count consecutive cycles the synchronised level disagrees with the stable level.
    always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
        cnt  <= '0;
        stab <= 1'b0;
        prs  <= 1'b0;
      end else begin
        prs <= 1'b0;
        if (sync_b[i] == stab) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          cnt  <= '0;
          stab <= sync_b[i];
          prs  <= sync_b[i];
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end

    assign press[i] = prs;
  end

  logic [1:0]    fifo_mem [Q_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic       press_any;
  logic [1:0] cand;
  logic [1:0] ref_dir;
  logic       q_empty;
  logic       q_full;
  logic       same_dir;
  logic       opp_dir;
  logic       reject;
  logic       do_push;
  logic       do_pop;

  // Pick one press (right > left > down > up) and judge it against the newest pending direction.
  always_comb begin
    press_any = |press;
    if (press[3])      cand = 2'b11;
    else if (press[0]) cand = 2'b00;
    else if (press[1]) cand = 2'b01;
    else               cand = 2'b10;

    q_empty = (q_level == '0);
    q_full  = (q_level == LVL_FULL);
    // The tail entry is what the snake will be heading after all queued turns apply.
    ref_dir = q_empty ? dir : fifo_mem[wr_ptr - PW'(1)];

    same_dir = (cand == ref_dir);
`ifdef SNAKE_DIR_REVERSAL_GUARD_EN
    opp_dir  = ((cand ^ ref_dir) == 2'b11);
`else
    opp_dir  = 1'b0;
`endif
    reject  = same_dir | opp_dir;
    do_push = press_any & ~reject & ~q_full & ~game_clear;
    do_pop  = move_tick & ~q_empty & ~game_clear;
  end

  // Queue storage; entries need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo_mem[wr_ptr] <= cand;
    end
  end

  // Queue pointers, current direction and status flags; game_clear overrides press and tick.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_level <= '0;
      dir     <= INIT_DIR;
      turned  <= 1'b0;
      drop    <= 1'b0;
      ovf     <= 1'b0;
    end else if (game_clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_level <= '0;
      dir     <= INIT_DIR;
      turned  <= 1'b0;
      drop    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      turned <= do_pop;
      drop   <= press_any & (reject | q_full);
      if (press_any && !reject && q_full) begin
        ovf <= 1'b1;
      end
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        dir    <= fifo_mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   q_level <= q_level + LW'(1);
        2'b01:   q_level <= q_level - LW'(1);
        default: q_level <= q_level;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Bench for snake_dir_ctrl with DEB_CYCLES=4, Q_DEPTH=2.
// Directed vector table first, then a randomized run against a behavioural queue model.
// Expectations for opposite-direction presses follow whether the reversal guard macro is defined.
module tb_snake_dir_ctrl;

  localparam int DEB = 4;
  localparam int QD  = 2;
`ifdef SNAKE_DIR_REVERSAL_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clear_n;
  logic [3:0] btn;
  logic       move_tick;
  logic       game_clear;
  logic [1:0] dir;
  logic       turned;
  logic [1:0] q_level;
  logic       drop;
  logic       ovf;

  always #5 clk = ~clk;

  snake_dir_ctrl #(.DEB_CYCLES(DEB), .Q_DEPTH(QD), .INIT_DIR(2'b11)) dut (
    .clk(clk), .clear_n(clear_n), .btn(btn), .move_tick(move_tick),
    .game_clear(game_clear), .dir(dir), .turned(turned), .q_level(q_level),
    .drop(drop), .ovf(ovf)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- behavioural model ----------------
  logic [3:0] m_raw [$];     // raw samples still in flight through the synchroniser
  logic [3:0] m_syn [$];     // most recent DEB synchronised samples
  logic [3:0] m_stable;
  logic [3:0] m_pv;          // press events visible this cycle
  logic [1:0] m_q [$];
  logic [1:0] m_dir;
  logic       m_turned, m_drop, m_ovf;

  task automatic model_reset();
    m_raw.delete(); m_raw.push_back(4'h0); m_raw.push_back(4'h0);
    m_syn.delete();
    m_stable = '0; m_pv = '0;
    m_q.delete();
    m_dir = 2'b11; m_turned = 0; m_drop = 0; m_ovf = 0;
  endtask

  function automatic logic [1:0] pick(input logic [3:0] p);
    if (p[3]) return 2'd3;
    if (p[0]) return 2'd0;
    if (p[1]) return 2'd1;
    return 2'd2;
  endfunction

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic model_step();
    logic [3:0] sv, npv;
    logic [1:0] cand, refd;
    bit push, all_diff;
    if (!clear_n) begin model_reset(); return; end
    push = 0;
    cand = pick(m_pv);
    if (game_clear) begin
      m_q.delete(); m_dir = 2'b11; m_ovf = 0; m_turned = 0; m_drop = 0;
    end else begin
      m_turned = 0; m_drop = 0;
      if (m_pv != 0) begin
        refd = (m_q.size() > 0) ? m_q[$] : m_dir;
        if (cand == refd || (GUARD && ((cand ^ refd) == 2'b11))) m_drop = 1;
        else if (m_q.size() >= QD) begin m_drop = 1; m_ovf = 1; end
        else push = 1;
      end
      if (move_tick && m_q.size() > 0) begin m_dir = m_q.pop_front(); m_turned = 1; end
      if (push) m_q.push_back(cand);
    end
    sv = m_raw.pop_front();
    m_raw.push_back(btn);
    m_syn.push_back(sv);
    if (m_syn.size() > DEB) void'(m_syn.pop_front());
    npv = '0;
    if (m_syn.size() == DEB) begin
      for (int i = 0; i < 4; i++) begin
        all_diff = 1;
        foreach (m_syn[j]) if (m_syn[j][i] == m_stable[i]) all_diff = 0;
        if (all_diff) begin
          m_stable[i] = ~m_stable[i];
          npv[i] = m_stable[i];
        end
      end
    end
    m_pv = npv;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic check_all(input string tag, input int e_dir, input int e_tr,
                           input int e_q, input int e_dr, input int e_ov);
    chk({tag, ".dir"},     int'(dir),     e_dir);
    chk({tag, ".turned"},  int'(turned),  e_tr);
    chk({tag, ".q_level"}, int'(q_level), e_q);
    chk({tag, ".drop"},    int'(drop),    e_dr);
    chk({tag, ".ovf"},     int'(ovf),     e_ov);
  endtask

  task automatic check_model(input string tag);
    check_all(tag, int'(m_dir), int'(m_turned), m_q.size(), int'(m_drop), int'(m_ovf));
  endtask

  // One clock with the present inputs; returns 1 time unit after the rising edge.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0] b;
    logic       t;
    logic       g;
    int         hold;
    int         e_dir, e_tr, e_q, e_dr, e_ov;
  } vec_t;

  vec_t vt [$];

  task automatic add_v(input logic [3:0] b, input logic t, input logic g, input int hold,
                       input int e_dir, input int e_tr, input int e_q, input int e_dr, input int e_ov);
    vec_t v;
    v.b = b; v.t = t; v.g = g; v.hold = hold;
    v.e_dir = e_dir; v.e_tr = e_tr; v.e_q = e_q; v.e_dr = e_dr; v.e_ov = e_ov;
    vt.push_back(v);
  endtask

  initial begin
    clear_n = 1'b0; btn = '0; move_tick = 0; game_clear = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 3, 0, 0, 0, 0);
    clear_n = 1'b1;

    // idle, then a 3-cycle glitch that must not become a press
    add_v(4'h0, 0, 0, 2, 3, 0, 0, 0, 0);
    add_v(4'h1, 0, 0, 3, 3, 0, 0, 0, 0);
    add_v(4'h0, 0, 0, 8, 3, 0, 0, 0, 0);
    // held left from right: opposite (guard rejects, otherwise queued)
    add_v(4'h1, 0, 0, 7, 3, 0, GUARD ? 0 : 1, GUARD ? 1 : 0, 0);
    add_v(4'h0, 0, 0, 6, 3, 0, GUARD ? 0 : 1, 0, 0);
    add_v(4'h0, 1, 0, 1, GUARD ? 3 : 0, GUARD ? 0 : 1, 0, 0, 0);
    add_v(4'h0, 0, 1, 1, 3, 0, 0, 0, 0);
    // down queued, up opposite of tail
    add_v(4'h2, 0, 0, 7, 3, 0, 1, 0, 0);
    add_v(4'h0, 0, 0, 6, 3, 0, 1, 0, 0);
    add_v(4'h4, 0, 0, 7, 3, 0, GUARD ? 1 : 2, GUARD ? 1 : 0, 0);
    add_v(4'h0, 0, 0, 6, 3, 0, GUARD ? 1 : 2, 0, 0);
    add_v(4'h0, 1, 0, 1, 1, 1, GUARD ? 0 : 1, 0, 0);
    add_v(4'h0, 0, 1, 1, 3, 0, 0, 0, 0);
    // up, left queued; down overflows; two ticks drain
    add_v(4'h4, 0, 0, 7, 3, 0, 1, 0, 0);
    add_v(4'h0, 0, 0, 6, 3, 0, 1, 0, 0);
    add_v(4'h1, 0, 0, 7, 3, 0, 2, 0, 0);
    add_v(4'h0, 0, 0, 6, 3, 0, 2, 0, 0);
    add_v(4'h2, 0, 0, 7, 3, 0, 2, 1, 1);
    add_v(4'h0, 0, 0, 6, 3, 0, 2, 0, 1);
    add_v(4'h0, 1, 0, 1, 2, 1, 1, 0, 1);
    add_v(4'h0, 1, 0, 1, 0, 1, 0, 0, 1);
    add_v(4'h0, 0, 0, 1, 0, 0, 0, 0, 1);
    // press with tick on empty queue: no bypass
    add_v(4'h4, 0, 0, 6, 0, 0, 0, 0, 1);
    add_v(4'h4, 1, 0, 1, 0, 0, 1, 0, 1);
    add_v(4'h0, 0, 0, 6, 0, 0, 1, 0, 1);
    add_v(4'h0, 1, 0, 1, 2, 1, 0, 0, 1);
    // simultaneous push and pop keeps the level
    add_v(4'h1, 0, 0, 7, 2, 0, 1, 0, 1);
    add_v(4'h0, 0, 0, 6, 2, 0, 1, 0, 1);
    add_v(4'h2, 0, 0, 6, 2, 0, 1, 0, 1);
    add_v(4'h2, 1, 0, 1, 0, 1, 1, 0, 1);
    add_v(4'h0, 0, 0, 6, 0, 0, 1, 0, 1);
    add_v(4'h0, 1, 0, 1, 1, 1, 0, 0, 1);
    // priority among simultaneous presses
    add_v(4'hF, 0, 0, 7, 1, 0, 1, 0, 1);
    add_v(4'h0, 0, 0, 6, 1, 0, 1, 0, 1);
    add_v(4'h0, 1, 0, 1, 3, 1, 0, 0, 1);
    add_v(4'h6, 0, 0, 7, 3, 0, 1, 0, 1);
    add_v(4'h0, 0, 0, 6, 3, 0, 1, 0, 1);
    add_v(4'h0, 1, 0, 1, 1, 1, 0, 0, 1);
    add_v(4'h3, 0, 0, 7, 1, 0, 1, 0, 1);
    add_v(4'h0, 0, 0, 6, 1, 0, 1, 0, 1);
    add_v(4'h0, 1, 0, 1, 0, 1, 0, 0, 1);
    // game_clear beats a coincident press and tick; held button does not re-fire
    add_v(4'h2, 0, 0, 7, 0, 0, 1, 0, 1);
    add_v(4'h0, 0, 0, 6, 0, 0, 1, 0, 1);
    add_v(4'h8, 0, 0, 6, 0, 0, 1, 0, 1);
    add_v(4'h8, 1, 1, 1, 3, 0, 0, 0, 0);
    add_v(4'h8, 0, 0, 3, 3, 0, 0, 0, 0);
    add_v(4'h0, 0, 0, 6, 3, 0, 0, 0, 0);

    for (int k = 0; k < vt.size(); k++) begin
      btn = vt[k].b; move_tick = vt[k].t; game_clear = vt[k].g;
      for (int c = 0; c < vt[k].hold; c++) cyc();
      check_all($sformatf("vec%0d", k), vt[k].e_dir, vt[k].e_tr, vt[k].e_q, vt[k].e_dr, vt[k].e_ov);
    end
    move_tick = 0; game_clear = 0;

    // asynchronous reset mid-queue and mid-debounce
    btn = 4'h2;
    for (int c = 0; c < 7; c++) cyc();
    btn = 4'h0;
    for (int c = 0; c < 6; c++) cyc();
    check_all("prerst", 3, 0, 1, 0, 0);
    btn = 4'h1;
    for (int c = 0; c < 4; c++) cyc();
    clear_n = 1'b0;
    model_reset();
    #1;
    check_all("midrst", 3, 0, 0, 0, 0);
    cyc();
    clear_n = 1'b1;
    for (int c = 0; c < 6; c++) cyc();
    check_all("rst_deb6", 3, 0, 0, 0, 0);
    cyc();
    check_all("rst_deb7", 3, 0, GUARD ? 0 : 1, GUARD ? 1 : 0, 0);
    btn = 4'h0;
    for (int c = 0; c < 6; c++) cyc();
    check_model("post_rst");

    // randomized run against the model
    for (int s = 0; s < 400; s++) begin
      int sel, hold;
      sel = $urandom_range(0, 3);
      if (sel == 0)      btn = 4'h0;
      else if (sel == 3) btn = 4'($urandom_range(0, 15));
      else               btn = 4'(1 << $urandom_range(0, 3));
      hold = $urandom_range(1, 12);
      for (int c = 0; c < hold; c++) begin
        move_tick  = ($urandom_range(0, 5) == 0);
        game_clear = ($urandom_range(0, 149) == 0);
        if ($urandom_range(0, 599) == 0) begin
          clear_n = 1'b0;
          model_reset();
          #1;
          check_model("rand_rst");
          cyc();
          clear_n = 1'b1;
        end
        cyc();
        check_model("rand");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
